// File: rtl/hash_lane_arbiter_if.sv
// Bundle of lane-side, comparator-side and host-side signals of the hash lane arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface hash_lane_arbiter_if #(
  parameter int LANES   = 4,
  parameter int NONCE_W = 32
);
  localparam int LID_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                     stop;
  logic [LANES-1:0]         lane_req;
  logic [LANES*256-1:0]     lane_hash;
  logic [LANES*NONCE_W-1:0] lane_nonce;
  logic [LANES-1:0]         lane_ack;
  logic [63:0]              beat_data;
  logic                     beat_we;
  logic                     beat_re;
  logic                     cmp_valid;
  logic                     cmp_hit;
  logic                     golden_valid;
  logic                     golden_ready;
  logic [NONCE_W-1:0]       golden_nonce;
  logic [LID_W-1:0]         golden_lane;
  logic                     busy;

  modport slave (
    input  stop, lane_req, lane_hash, lane_nonce, beat_re, cmp_valid, cmp_hit, golden_ready,
    output lane_ack, beat_data, beat_we, golden_valid, golden_nonce, golden_lane, busy
  );

  modport master (
    output stop, lane_req, lane_hash, lane_nonce, beat_re, cmp_valid, cmp_hit, golden_ready,
    input  lane_ack, beat_data, beat_we, golden_valid, golden_nonce, golden_lane, busy
  );
endinterface

// File: rtl/hash_lane_arbiter.sv
// Round-robin scheduler sharing one hash/target comparator among LANES hash cores.
// Captures a granted lane's hash and nonce, streams the hash as four 64-bit beats
// (MSB word first), waits for the verdict and forwards hits as golden records.
module hash_lane_arbiter #(
  parameter int LANES   = 4,
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,   // asynchronous, active-low
  hash_lane_arbiter_if.slave bus
);

  localparam int LID_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RES,
    S_PUSH
  } state_e;

  state_e             state_q;
  logic [LID_W-1:0]   rr_ptr_q;
  logic [1:0]         beat_cnt_q;
  logic [255:0]       hash_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [LID_W-1:0]   lane_q;
  logic               ack_q;
  logic               beat_we_q;
  logic [63:0]        beat_data_q;
  logic               golden_valid_q;
  logic [NONCE_W-1:0] golden_nonce_q;
  logic [LID_W-1:0]   golden_lane_q;
  logic               busy_q;

  logic               grant_vld;
  logic [LID_W-1:0]   grant_idx;
  logic [LID_W-1:0]   rr_ptr_d;
  logic [255:0]       sel_hash;
  logic [NONCE_W-1:0] sel_nonce;
  logic [LANES-1:0]   lane_ack_d;

  // Selects 64-bit word idx of a hash, word 0 being bits [255:192].
  function automatic logic [63:0] hash_word(input logic [255:0] h, input logic [1:0] idx);
    logic [63:0] w;
    case (idx)
      2'd0:    w = h[255:192];
      2'd1:    w = h[191:128];
      2'd2:    w = h[127:64];
      default: w = h[63:0];
    endcase
    return w;
  endfunction

  // Round-robin pick: first requesting lane at or after rr_ptr, wrapping upward.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!grant_vld && bus.lane_req[(int'(rr_ptr_q) + k) % LANES]) begin
        grant_vld = 1'b1;
        grant_idx = LID_W'((int'(rr_ptr_q) + k) % LANES);
      end
    end
    rr_ptr_d = (int'(grant_idx) == LANES - 1) ? '0 : grant_idx + LID_W'(1);
  end

  assign sel_hash  = bus.lane_hash[grant_idx*256 +: 256];
  assign sel_nonce = bus.lane_nonce[grant_idx*NONCE_W +: NONCE_W];

  // Scheduler FSM with registered outputs; stop overrides every other event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the hash/nonce capture registers are reset too, so nothing stale is visible after reset.
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      hash_q         <= '0;
      nonce_q        <= '0;
      lane_q         <= '0;
      ack_q          <= 1'b0;
      beat_we_q      <= 1'b0;
      beat_data_q    <= '0;
      golden_valid_q <= 1'b0;
      golden_nonce_q <= '0;
      golden_lane_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      ack_q <= 1'b0;
      if (bus.stop) begin
        state_q        <= S_IDLE;
        beat_we_q      <= 1'b0;
        golden_valid_q <= 1'b0;
        beat_cnt_q     <= '0;
        busy_q         <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (grant_vld) begin
              hash_q      <= sel_hash;
              nonce_q     <= sel_nonce;
              lane_q      <= grant_idx;
              ack_q       <= 1'b1;
              rr_ptr_q    <= rr_ptr_d;
              beat_cnt_q  <= '0;
              beat_we_q   <= 1'b1;
              beat_data_q <= sel_hash[255:192];
              busy_q      <= 1'b1;
              state_q     <= S_SEND;
            end
          end
          S_SEND: begin
            if (bus.beat_re) begin
              if (beat_cnt_q == 2'd3) begin
                beat_cnt_q <= '0;
                beat_we_q  <= 1'b0;
                state_q    <= S_WAIT_RES;
              end else begin
                beat_cnt_q  <= beat_cnt_q + 2'd1;
                beat_data_q <= hash_word(hash_q, beat_cnt_q + 2'd1);
              end
            end
          end
          S_WAIT_RES: begin
            if (bus.cmp_valid) begin
              if (bus.cmp_hit) begin
                golden_valid_q <= 1'b1;
                golden_nonce_q <= nonce_q;
                golden_lane_q  <= lane_q;
                state_q        <= S_PUSH;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
          S_PUSH: begin
            if (bus.golden_ready) begin
              golden_valid_q <= 1'b0;
              busy_q         <= 1'b0;
              state_q        <= S_IDLE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // One-hot acknowledge decoded from the registered grant.
  always_comb begin
    lane_ack_d = '0;
    if (ack_q) lane_ack_d[lane_q] = 1'b1;
  end

  assign bus.lane_ack     = lane_ack_d;
  assign bus.beat_data    = beat_data_q;
  assign bus.beat_we      = beat_we_q;
  assign bus.golden_valid = golden_valid_q;
  assign bus.golden_nonce = golden_nonce_q;
  assign bus.golden_lane  = golden_lane_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_hash_lane_arbiter.sv
// Directed self-checking bench for hash_lane_arbiter (LANES=4, NONCE_W=32).
module tb_hash_lane_arbiter;

  localparam int LANES   = 4;
  localparam int NONCE_W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [255:0] hashes [LANES];

  hash_lane_arbiter_if #(.LANES(LANES), .NONCE_W(NONCE_W)) bus ();

  hash_lane_arbiter #(.LANES(LANES), .NONCE_W(NONCE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wexp(input int lane, input int k);
    logic [255:0] h;
    h = hashes[lane];
    return h[255 - 64*k -: 64];
  endfunction

  // Grant expected lane, stream 4 beats, answer with a miss.
  task automatic run_miss(input int lane, input string tag);
    tick();
    check({tag, "_ack"}, 64'(bus.lane_ack), 64'(4'b0001 << lane));
    check({tag, "_b0"}, bus.beat_data, wexp(lane, 0));
    repeat (4) tick();
    check({tag, "_we_off"}, 64'(bus.beat_we), 64'd0);
    bus.cmp_valid = 1'b1;
    bus.cmp_hit   = 1'b0;
    tick();
    bus.cmp_valid = 1'b0;
    check({tag, "_gv"}, 64'(bus.golden_valid), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [6:0] bp_pat;
    int         n_xfer;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.stop = 1'b0;
    bus.lane_req = '0;
    bus.beat_re = 1'b1;
    bus.cmp_valid = 1'b0;
    bus.cmp_hit = 1'b0;
    bus.golden_ready = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      hashes[i] = {8'(8'hA0 + i), 56'h11_1111_1111_1111, 8'(8'hB0 + i), 56'h22_2222_2222_2222,
                   8'(8'hC0 + i), 56'h33_3333_3333_3333, 8'(8'hD0 + i), 56'h44_4444_4444_4444};
    end
    hashes[2] = 256'h0011223344556677_8899AABBCCDDEEFF_0123456789ABCDEF_FEDCBA9876543210;
    for (int i = 0; i < LANES; i++) begin
      bus.lane_hash[i*256 +: 256]          = hashes[i];
      bus.lane_nonce[i*NONCE_W +: NONCE_W] = 32'h1000_0000 + 32'(i);
    end
    bus.lane_nonce[2*NONCE_W +: NONCE_W] = 32'hDEADBEEF;

    // Reset state
    repeat (2) tick();
    check("rst_ack", 64'(bus.lane_ack), 64'd0);
    check("rst_we", 64'(bus.beat_we), 64'd0);
    check("rst_data", bus.beat_data, 64'd0);
    check("rst_gv", 64'(bus.golden_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    tick();

    // Single hash from lane 2 with a hit
    bus.lane_req = 4'b0100;
    tick();
    check("s_ack", 64'(bus.lane_ack), 64'h4);
    check("s_busy", 64'(bus.busy), 64'd1);
    check("s_we0", 64'(bus.beat_we), 64'd1);
    check("s_b0", bus.beat_data, 64'h0011223344556677);
    bus.lane_req = '0;
    tick();
    check("s_ack_once", 64'(bus.lane_ack), 64'd0);
    check("s_b1", bus.beat_data, 64'h8899AABBCCDDEEFF);
    tick();
    check("s_b2", bus.beat_data, 64'h0123456789ABCDEF);
    tick();
    check("s_b3", bus.beat_data, 64'hFEDCBA9876543210);
    check("s_we3", 64'(bus.beat_we), 64'd1);
    tick();
    check("s_we_off", 64'(bus.beat_we), 64'd0);
    check("s_wait_busy", 64'(bus.busy), 64'd1);
    bus.cmp_valid = 1'b1;
    bus.cmp_hit   = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    bus.cmp_hit   = 1'b0;
    check("s_gv", 64'(bus.golden_valid), 64'd1);
    check("s_gnonce", 64'(bus.golden_nonce), 64'hDEADBEEF);
    check("s_glane", 64'(bus.golden_lane), 64'd2);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("s_gv_hold", 64'(bus.golden_valid), 64'd1);
      check("s_gnonce_hold", 64'(bus.golden_nonce), 64'hDEADBEEF);
    end
    bus.golden_ready = 1'b1;
    tick();
    bus.golden_ready = 1'b0;
    check("s_gv_clr", 64'(bus.golden_valid), 64'd0);
    check("s_idle", 64'(bus.busy), 64'd0);

    // Wrap-around: rr_ptr=3, only lane 0, then lanes 0 and 1
    bus.lane_req = 4'b0001;
    run_miss(0, "wrap0");
    bus.lane_req = 4'b0011;
    run_miss(1, "wrap1");
    bus.lane_req = '0;

    // Asynchronous reset in the middle of SEND, after 2 beats
    bus.lane_req = 4'b0010;
    tick();
    check("mr_ack", 64'(bus.lane_ack), 64'h2);
    bus.lane_req = '0;
    repeat (2) tick();
    check("mr_b2", bus.beat_data, wexp(1, 2));
    #2 rst = 1'b0;
    #1;
    check("mr_we", 64'(bus.beat_we), 64'd0);
    check("mr_data", bus.beat_data, 64'd0);
    check("mr_busy", 64'(bus.busy), 64'd0);
    check("mr_gnonce", 64'(bus.golden_nonce), 64'd0);
    check("mr_glane", 64'(bus.golden_lane), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("mr_idle", 64'(bus.busy), 64'd0);

    // Round-robin from rr_ptr=0 with all lanes requesting, all misses
    bus.lane_req = 4'b1111;
    for (int n = 0; n < 6; n++) run_miss(n % LANES, $sformatf("rr%0d", n));
    bus.lane_req = '0;

    // Backpressure on lane 3, with a stray verdict during a stall
    bp_pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    n_xfer = 0;
    bus.lane_req = 4'b1000;
    tick();
    check("bp_ack", 64'(bus.lane_ack), 64'h8);
    bus.lane_req = '0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("bp_we%0d", i), 64'(bus.beat_we), 64'd1);
      check($sformatf("bp_data%0d", i), bus.beat_data, wexp(3, n_xfer));
      bus.beat_re = bp_pat[i];
      if (i == 1) begin
        bus.cmp_valid = 1'b1;
        bus.cmp_hit   = 1'b1;
      end
      tick();
      bus.cmp_valid = 1'b0;
      bus.cmp_hit   = 1'b0;
      if (bp_pat[i]) n_xfer++;
    end
    bus.beat_re = 1'b1;
    check("bp_we_end", 64'(bus.beat_we), 64'd0);
    check("bp_gv", 64'(bus.golden_valid), 64'd0);
    bus.cmp_valid = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    check("bp_idle", 64'(bus.busy), 64'd0);

    // stop during WAIT_RES (beats a simultaneous hit)
    bus.lane_req = 4'b0010;
    tick();
    check("st1_ack", 64'(bus.lane_ack), 64'h2);
    bus.lane_req = '0;
    repeat (4) tick();
    check("st1_wait", 64'(bus.busy), 64'd1);
    bus.stop      = 1'b1;
    bus.cmp_valid = 1'b1;
    bus.cmp_hit   = 1'b1;
    tick();
    bus.stop      = 1'b0;
    bus.cmp_valid = 1'b0;
    bus.cmp_hit   = 1'b0;
    check("st1_busy", 64'(bus.busy), 64'd0);
    check("st1_gv", 64'(bus.golden_valid), 64'd0);
    check("st1_we", 64'(bus.beat_we), 64'd0);

    // Next grant goes to the lane after the aborted one; then stop during PUSH
    bus.lane_req = 4'b1111;
    tick();
    check("st2_ack", 64'(bus.lane_ack), 64'h4);
    bus.lane_req = '0;
    repeat (4) tick();
    bus.cmp_valid = 1'b1;
    bus.cmp_hit   = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    bus.cmp_hit   = 1'b0;
    check("st2_gv", 64'(bus.golden_valid), 64'd1);
    check("st2_glane", 64'(bus.golden_lane), 64'd2);
    bus.stop         = 1'b1;
    bus.golden_ready = 1'b1;
    bus.lane_req     = 4'b1111;
    tick();
    bus.golden_ready = 1'b0;
    check("st2_gv_drop", 64'(bus.golden_valid), 64'd0);
    check("st2_busy", 64'(bus.busy), 64'd0);
    tick();
    check("st2_noack", 64'(bus.lane_ack), 64'd0);
    check("st2_hold_idle", 64'(bus.busy), 64'd0);
    bus.stop = 1'b0;
    tick();
    check("st2_next", 64'(bus.lane_ack), 64'h8);
    bus.lane_req = '0;
    repeat (4) tick();
    bus.cmp_valid = 1'b1;
    tick();
    bus.cmp_valid = 1'b0;
    check("end_idle", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
